// File: rtl/mips_prog_sequencer.sv
// mips_prog_sequencer
//   Program-image sequencer for the Harvard MIPS CPU. Holds a DEPTH-word
//   program, serves instruction fetches combinationally, controls CPU reset
//   and clock enable, runs until the CPU drops active (or times out) and then
//   grades register_v0 against expected_v0.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   prog_we/addr/data       program write port (IDLE only)
//   expected_v0             v0 value required at halt
//   start                   one-cycle run request (IDLE or DONE)
//   dut_reset               CPU reset, active high
//   dut_clk_enable          CPU clock enable
//   instr_address           CPU fetch address
//   instr_readdata          fetched word, NOP when outside the image
//   dut_active, register_v0 CPU status
//   busy, done, pass        run status
//   fail_code               0 pass, 1 v0 mismatch, 2 timeout, 3 bad fetch
//   cycle_count             RUN cycles, saturating
//
// Optional build macro: STALL_INJECT_EN -- pseudo-random clock-enable stalls
// in RUN driven by a 16-bit LFSR.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | CPU in reset, program port open, wait for start
// RESET_DUT | CPU reset with clock enabled for RESET_CYCLES
// RUN       | CPU executing, count cycles, watch fetches
// CHECK     | CPU frozen one cycle, grade v0
// DONE      | result held, CPU state left observable
module mips_prog_sequencer #(
  parameter int unsigned DEPTH          = 16,
  parameter logic [31:0] BASE_ADDR      = 32'hBFC00000,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  input  logic [31:0]              expected_v0,
  input  logic                     start,
  output logic                     dut_reset,
  output logic                     dut_clk_enable,
  input  logic [31:0]              instr_address,
  output logic [31:0]              instr_readdata,
  input  logic                     dut_active,
  input  logic [31:0]              register_v0,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [31:0]              cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LOAD     = RW'(RESET_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_DUT, S_RUN, S_CHECK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [31:0]   cycle_cnt_q, cycle_cnt_d;
  logic [1:0]    fail_code_q, fail_code_d;
  logic          bad_fetch_q, bad_fetch_d;
  logic          run_enable;

  logic [31:0] mem [DEPTH];

  // Fetch decode: subtracting the base lets addresses below it wrap to a large
  // offset, so a single upper-bits-zero test covers both ends of the window.
  logic [31:0]   fetch_off;
  logic          fetch_ok;
  logic [AW-1:0] fetch_idx;

  assign fetch_off      = instr_address - BASE_ADDR;
  assign fetch_ok       = (instr_address[1:0] == 2'b00) && ((fetch_off >> (AW + 2)) == 32'd0);
  assign fetch_idx      = fetch_off[AW+1:2];
  assign instr_readdata = fetch_ok ? mem[fetch_idx] : 32'h0;

  // Program RAM survives reset on purpose so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

`ifdef STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // x^16 + x^14 + x^13 + x^11 + 1, free-running so stalls are not tied to run start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign run_enable = (lfsr_q[1:0] != 2'b00);
`else
  assign run_enable = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      fail_code_q <= 2'd0;
      bad_fetch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      fail_code_q <= fail_code_d;
      bad_fetch_q <= bad_fetch_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    cycle_cnt_d    = cycle_cnt_q;
    fail_code_d    = fail_code_q;
    bad_fetch_d    = bad_fetch_q;
    dut_reset      = 1'b1;
    dut_clk_enable = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    pass           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RESET_DUT;
          rst_cnt_d   = RST_LOAD;
          cycle_cnt_d = '0;
          fail_code_d = 2'd0;
          bad_fetch_d = 1'b0;
        end
      end

      S_RESET_DUT: begin
        dut_clk_enable = 1'b1;
        busy           = 1'b1;
        if (rst_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RW'(1);
        end
      end

      S_RUN: begin
        dut_reset      = 1'b0;
        dut_clk_enable = run_enable;
        busy           = 1'b1;
        // The halt fetch of address 0 happens with active low, so it never flags.
        if (dut_active && !fetch_ok) begin
          bad_fetch_d = 1'b1;
        end
        if (!dut_active) begin
          state_d = S_CHECK;
          if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
        end else if (cycle_cnt_q == TIMEOUT_LAST) begin
          // The terminal cycle is not counted: a timeout reports TIMEOUT_CYCLES-1.
          state_d     = S_DONE;
          fail_code_d = 2'd2;
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
      end

      S_CHECK: begin
        dut_reset = 1'b0;
        busy      = 1'b1;
        state_d   = S_DONE;
        if (bad_fetch_q) begin
          fail_code_d = 2'd3;
        end else if (register_v0 != expected_v0) begin
          fail_code_d = 2'd1;
        end else begin
          fail_code_d = 2'd0;
        end
      end

      S_DONE: begin
        dut_reset = 1'b0;
        done      = 1'b1;
        pass      = (fail_code_q == 2'd0);
        if (start) begin
          state_d     = S_RESET_DUT;
          rst_cnt_d   = RST_LOAD;
          cycle_cnt_d = '0;
          fail_code_d = 2'd0;
          bad_fetch_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_mips_prog_sequencer.sv
// Bench for mips_prog_sequencer: an ISA-level CPU model is the device under
// sequencing; outcomes are predicted by running the program image through the
// same instruction semantics in plain procedural code.
module tb_mips_prog_sequencer;

  localparam int          DEPTH        = 16;
  localparam int          AW           = 4;
  localparam logic [31:0] BASE         = 32'hBFC00000;
  localparam int          RESET_CYCLES = 2;
  localparam int          TIMEOUT      = 50;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [31:0]   expected_v0 = '0;
  logic          start = 1'b0;
  logic          dut_reset, dut_clk_enable, busy, done, pass;
  logic [31:0]   instr_address, instr_readdata, register_v0, cycle_count;
  logic [1:0]    fail_code;
  logic          cpu_active;

  logic          probe_en = 1'b0;
  logic [31:0]   probe_addr = '0;

  int total = 0;
  int bad = 0;
  int stall_seen = 0;

  logic [31:0] img [DEPTH];

  always #5 clk = ~clk;

  mips_prog_sequencer #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .RESET_CYCLES(RESET_CYCLES), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .expected_v0(expected_v0), .start(start),
    .dut_reset(dut_reset), .dut_clk_enable(dut_clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .dut_active(cpu_active), .register_v0(register_v0), .busy(busy), .done(done),
    .pass(pass), .fail_code(fail_code), .cycle_count(cycle_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- ISA semantics (addiu, addu, jr, beq, j) ----------------
  function automatic void isa_exec(input logic [31:0] ins, input logic [31:0] rs_v,
                                   input logic [31:0] rt_v, input logic [31:0] npc,
                                   output logic [4:0] wi, output logic [31:0] wv,
                                   output logic [31:0] tgt);
    logic [31:0] simm;
    simm = {{16{ins[15]}}, ins[15:0]};
    wi = 5'd0; wv = 32'd0; tgt = npc + 32'd4;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21) begin wi = ins[15:11]; wv = rs_v + rt_v; end
        else if (ins[5:0] == 6'h08) tgt = rs_v;
      end
      6'h09: begin wi = ins[20:16]; wv = rs_v + simm; end
      6'h04: if (rs_v == rt_v) tgt = npc + (simm << 2);
      6'h02: tgt = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
  endfunction

  function automatic logic fetch_legal(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (off < 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return fetch_legal(a) ? img[off[AW+1:2]] : 32'h0;
  endfunction

  // ---------------- CPU model driven by the sequencer ----------------
  logic [31:0] cpu_pc = BASE;
  logic [31:0] cpu_npc = BASE + 32'd4;
  logic [31:0] cpu_regs [32];
  logic [4:0]  cpu_wi;
  logic [31:0] cpu_wv, cpu_tgt;

  assign cpu_active    = (cpu_pc != 32'd0);
  assign register_v0   = cpu_regs[2];
  assign instr_address = probe_en ? probe_addr : cpu_pc;

  always_comb begin
    cpu_wi = 5'd0; cpu_wv = 32'd0; cpu_tgt = 32'd0;
    isa_exec(instr_readdata, cpu_regs[instr_readdata[25:21]], cpu_regs[instr_readdata[20:16]],
             cpu_npc, cpu_wi, cpu_wv, cpu_tgt);
  end

  always @(posedge clk) begin
    if (dut_reset) begin
      cpu_pc  <= BASE;
      cpu_npc <= BASE + 32'd4;
      for (int i = 0; i < 32; i++) cpu_regs[i] <= 32'd0;
    end else if (dut_clk_enable && cpu_active) begin
      if (cpu_wi != 5'd0) cpu_regs[cpu_wi] <= cpu_wv;
      cpu_pc  <= cpu_npc;
      cpu_npc <= cpu_tgt;
    end
  end

  // ---------------- reference prediction ----------------
  task automatic predict(output logic [31:0] v0, output int steps, output logic badf,
                         output logic halted);
    logic [31:0] r [32];
    logic [31:0] pc, npc, ins, wv, tgt;
    logic [4:0]  wi;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = BASE; npc = BASE + 32'd4; steps = 0; badf = 1'b0;
    while (pc != 32'd0 && steps < TIMEOUT) begin
      if (!fetch_legal(pc)) badf = 1'b1;
      ins = ref_fetch(pc);
      isa_exec(ins, r[ins[25:21]], r[ins[20:16]], npc, wi, wv, tgt);
      if (wi != 5'd0) r[wi] = wv;
      pc = npc; npc = tgt; steps++;
    end
    halted = (pc == 32'd0) && (steps <= TIMEOUT - 1);
    v0 = r[2];
  endtask

  // ---------------- program builders ----------------
  function automatic logic [31:0] enc_addiu(input logic [4:0] rt, input logic [4:0] rs,
                                            input logic [15:0] imm);
    return {6'h09, rs, rt, imm};
  endfunction

  task automatic build_addu(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < DEPTH; i++) img[i] = 32'd0;
    img[0] = enc_addiu(5'd3, 5'd1, a);
    img[1] = enc_addiu(5'd1, 5'd3, b);
    img[2] = 32'h00611021;
    img[3] = 32'h00000008;
  endtask

  task automatic build_timeout();
    for (int i = 0; i < DEPTH; i++) img[i] = 32'd0;
    img[0] = 32'h1000FFFF;
  endtask

  // Jump to the last word, whose jr $0 has its delay slot just past the image.
  task automatic build_badfetch(input logic [15:0] a);
    logic [31:0] t;
    for (int i = 0; i < DEPTH; i++) img[i] = 32'd0;
    t = BASE + 32'(4 * (DEPTH - 1));
    img[0] = enc_addiu(5'd2, 5'd0, a);
    img[1] = {6'h02, t[27:2]};
    img[DEPTH-1] = 32'h00000008;
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic load_image();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); prog_we = 1'b1; prog_addr = AW'(i); prog_data = img[i];
    end
    @(negedge clk); prog_we = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] a);
    probe_en = 1'b1; probe_addr = a;
    #1;
    check_val(tag, instr_readdata, ref_fetch(a));
    probe_en = 1'b0;
  endtask

  task automatic random_probes(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        1: a = BASE + 32'(4 * DEPTH);
        2: a = BASE - 32'd4;
        3: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      probe("fetch", a);
    end
  endtask

  task automatic run_prog(input string tag, input logic [31:0] exp_v0, input bit wr_on_start,
                          input logic [AW-1:0] wa, input logic [31:0] wd);
    logic [31:0] pv0;
    int          steps, lat, guard;
    logic        badf, halted;
    logic [1:0]  ecode;
    if (wr_on_start) img[wa] = wd;
    predict(pv0, steps, badf, halted);
    ecode = !halted ? 2'd2 : badf ? 2'd3 : (pv0 != exp_v0) ? 2'd1 : 2'd0;
    expected_v0 = exp_v0;

    @(negedge clk);
    start = 1'b1; prog_we = wr_on_start; prog_addr = wa; prog_data = wd;
    lat = 0;
    do begin
      @(negedge clk); start = 1'b0; prog_we = 1'b0; lat++;
      if (lat == 1) check_val({tag, ".rst_en"}, {dut_reset, dut_clk_enable, busy}, 3'b111);
    end while (dut_reset && lat < 10);
    check_val({tag, ".latency"}, lat, RESET_CYCLES + 1);
    check_val({tag, ".busy_run"}, busy, 1'b1);

    // Start and program writes must both be ignored mid-run.
    @(negedge clk); start = 1'b1; prog_we = 1'b1; prog_addr = AW'(DEPTH - 2); prog_data = 32'hDEADBEEF;
    @(negedge clk); start = 1'b0; prog_we = 1'b0;

    guard = 0;
    while (!done && guard < TIMEOUT + 20) begin
      @(negedge clk); guard++;
    end
    check_val({tag, ".done_seen"}, done, 1'b1);
    check_val({tag, ".fail_code"}, fail_code, ecode);
    check_val({tag, ".pass"}, pass, (ecode == 2'd0));
    check_val({tag, ".idle_outs"}, {busy, dut_reset, dut_clk_enable}, 3'b000);
`ifdef STALL_INJECT_EN
    if (halted) begin
      check_val({tag, ".cyc_min"}, (cycle_count >= 32'(steps + 1)), 1'b1);
      if (cycle_count > 32'(steps + 1)) stall_seen++;
    end else begin
      check_val({tag, ".cyc_to"}, cycle_count, TIMEOUT - 1);
    end
`else
    check_val({tag, ".cycles"}, cycle_count, halted ? 32'(steps + 1) : 32'(TIMEOUT - 1));
`endif
    if (halted) check_val({tag, ".v0"}, register_v0, pv0);
    @(negedge clk);
    check_val({tag, ".done_hold"}, {done, fail_code}, {1'b1, ecode});
    probe({tag, ".no_write"}, BASE + 32'(4 * (DEPTH - 2)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    logic [31:0] ev;
    int          kind;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_val("rst.outs", {dut_reset, dut_clk_enable, busy, done, pass}, 5'b10000);
    check_val("rst.fail_code", fail_code, 2'd0);
    check_val("rst.cycles", cycle_count, 32'd0);
    reset_n = 1'b1;

    // Reference ADDU program: pass, then v0 mismatch restarted from DONE
    build_addu(16'd20, 16'd20);
    load_image();
    random_probes(6);
    run_prog("addu", 32'h3C, 1'b0, '0, '0);
    run_prog("addu_bad_v0", 32'h60, 1'b0, '0, '0);

    // Timeout
    do_reset();
    build_timeout();
    load_image();
    run_prog("timeout", 32'h0, 1'b0, '0, '0);

    // Bad fetch wins even with a matching v0
    do_reset();
    build_badfetch(16'h0042);
    load_image();
    run_prog("badfetch", 32'h42, 1'b0, '0, '0);

    // Abort mid-run, then rerun the retained image
    do_reset();
    build_addu(16'd20, 16'd20);
    load_image();
    expected_v0 = 32'h3C;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("abort.outs", {dut_reset, dut_clk_enable, busy, done, pass}, 5'b10000);
    check_val("abort.cycles", cycle_count, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_prog("rerun", 32'h3C, 1'b0, '0, '0);

    // Write and start in the same IDLE cycle
    do_reset();
    build_addu(16'd20, 16'd20);
    img[0] = 32'h24020077;
    load_image();
    run_prog("we_start", 32'h3C, 1'b1, '0, enc_addiu(5'd3, 5'd1, 16'd20));

    // Randomized programs
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      a = 16'($urandom_range(0, 16'h3FFF));
      b = 16'($urandom_range(0, 16'h3FFF));
      case (kind)
        0: begin
          build_addu(a, b);
          ev = ($urandom_range(0, 1) == 1) ? (32'(a) * 2 + 32'(b)) : $urandom;
        end
        1: begin build_timeout(); ev = $urandom; end
        default: begin build_badfetch(a); ev = ($urandom_range(0, 1) == 1) ? 32'(a) : $urandom; end
      endcase
      do_reset();
      load_image();
      random_probes(4);
      run_prog($sformatf("rand%0d", it), ev, 1'b0, '0, '0);
    end

`ifdef STALL_INJECT_EN
    check_val("stall.seen", (stall_seen > 0), 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_prog_sequencer.md
Name: mips_prog_sequencer

Overview:
Self-checking, parametrised instruction sequencer that drives the Harvard MIPS CPU (mips_cpu_harvard) in place of hand-written per-instruction stimulus. Holds a DEPTH-entry program image, serves instruction fetches combinationally, and manages DUT reset and clock enable. Runs until the CPU drops `active` or a timeout expires, then compares register_v0 against an expected value. One instance per CPU-level regression; programs are loaded through a write port, so no bench edits are needed per instruction.

Parameters:
DEPTH, 16, program words held (power of 2, 4..1024)
BASE_ADDR, 32'hBFC00000, byte address of program word 0 (CPU reset vector)
RESET_CYCLES, 2, cycles dut_reset is held high after start
TIMEOUT_CYCLES, 10000, run cycles before declaring timeout

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
prog_we  in  1  program write strobe (honoured in IDLE only)
prog_addr  in  $clog2(DEPTH)  program word index
prog_data  in  32  instruction word
expected_v0  in  32  value register_v0 must hold at halt
start  in  1  single-cycle pulse: begin run
dut_reset  out  1  to CPU reset (active-high)
dut_clk_enable  out  1  to CPU clk_enable
instr_address  in  32  from CPU
instr_readdata  out  32  to CPU, combinational
dut_active  in  1  CPU active
register_v0  in  32  CPU v0
busy  out  1  high in RESET_DUT/RUN/CHECK
done  out  1  high in DONE until next start
pass  out  1  valid while done
fail_code  out  2  0 pass, 1 v0 mismatch, 2 timeout, 3 bad fetch
cycle_count  out  32  RUN cycles elapsed, saturating at 2^32-1

Behaviour:
- Reset (async, reset_n=0): state IDLE; dut_reset=1, dut_clk_enable=0, busy=0, done=0, pass=0, fail_code=0, cycle_count=0, bad-fetch flag=0. Program RAM is not cleared. Reset mid-run aborts immediately to IDLE.
- Fetch: idx=(instr_address-BASE_ADDR)>>2. If instr_address[1:0]==0 and 0<=idx<DEPTH, instr_readdata=mem[idx], otherwise 32'h0 (NOP). Zero latency.
- Bad fetch: an out-of-range or misaligned address sampled while in RUN and dut_active=1 sets a sticky flag. Address 0 fetched after dut_active falls is the halt fetch and is not flagged.
- FSM:
  - IDLE: dut_reset=1, enable=0. prog_we writes mem on the clock edge. start -> RESET_DUT and clears done, pass, fail_code, cycle_count and the flag.
  - RESET_DUT: dut_reset=1, enable=1, count RESET_CYCLES cycles -> RUN.
  - RUN: dut_reset=0, enable=1, cycle_count++ each cycle. If dut_active=0 -> CHECK. Else if cycle_count==TIMEOUT_CYCLES-1 -> DONE with fail_code=2.
  - CHECK: enable=0 for one cycle; v0 is sampled here. Flag set -> fail_code=3; else v0!=expected_v0 -> 1; else 0. Next state DONE.
  - DONE: done=1, pass=(fail_code==0), enable=0, dut_reset=0 (CPU state stays observable). start -> RESET_DUT.
- Latency: start edge to dut_reset falling edge = RESET_CYCLES+1 cycles.
- Ignored events: start outside IDLE/DONE. prog_we outside IDLE.
- Simultaneous events: start and prog_we in the same IDLE cycle -> the write commits and the run starts. Timeout and active falling in the same cycle -> active wins (CHECK).
- Priority in CHECK: 3 > 1.

Optional Feature:
STALL_INJECT_EN. When defined, a 16-bit LFSR (seed 16'hACE1, reset on reset_n) gates dut_clk_enable in RUN: enable=0 when lfsr[1:0]==2'b00. cycle_count still increments every cycle, so the timeout counts wall-clock cycles. When undefined, enable is constant 1 in RUN and the LFSR is absent. All other behaviour is identical.

Test Plan:
- Load [0]=0x24230014 (addiu $3,$1,20), [1]=0x24610014 (addiu $1,$3,20), [2]=0x00611021 (addu $2,$3,$1), [3]=0x00000008 (jr $0), [4]=0; expected_v0=32'h3C; start -> done=1, pass=1, fail_code=0, dut_reset low exactly RESET_CYCLES+1 cycles after start.
- Same program, expected_v0=32'h60 -> done=1, pass=0, fail_code=1.
- Program [0]=0x1000FFFF (b self), [1]=0, TIMEOUT_CYCLES=50 -> done on cycle 50 of RUN, fail_code=2, cycle_count=49.
- Program jumping to BASE_ADDR+4*DEPTH while active -> fail_code=3 even when v0 matches.
- Deassert reset_n during RUN -> next sample shows IDLE, dut_reset=1, busy=0, done=0. Rerun without reloading the program -> pass=1.
- With STALL_INJECT_EN: ADDU program -> pass=1, v0=0x3C, and cycle_count strictly greater than in the non-stall run.
